// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: round-robin burst scheduler sharing one async-FIFO read port among consumers
module fifo_rd_sched #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  parameter int EMPTY_TMO = 8,
  parameter int DATASIZE  = 8
) (
  input  logic                i_rclk,
  input  logic                i_rrst,
  input  logic [NUM_REQ-1:0]  i_req,
  output logic [NUM_REQ-1:0]  o_gnt,
  input  logic                i_fifo_empty,
  output logic                o_fifo_rden,
  input  logic [DATASIZE-1:0] i_fifo_data,
  output logic [DATASIZE-1:0] o_data,
  output logic [NUM_REQ-1:0]  o_valid,
  output logic                o_busy
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(EMPTY_TMO + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t        state;
  logic [PW-1:0] ptr, win, rd_idx;
  logic [BW-1:0] beat;
  logic [TW-1:0] tmo;
  logic          rd_q, last_beat, tmo_hit, stall;
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [PW-1:0] p);
    logic [PW-1:0] k;
    rr_pick = p;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = PW'((int'(p) + i) % NUM_REQ);
      if (req[k]) rr_pick = k;
    end
  endfunction
  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] k);
    onehot = '0;
    onehot[k] = 1'b1;
  endfunction
  assign win         = rr_pick(i_req, ptr);
  assign o_fifo_rden = state == BURST && i_req[ptr] && !i_fifo_empty;
  assign stall       = state == BURST && i_req[ptr] && i_fifo_empty;
  assign last_beat   = o_fifo_rden && beat == BW'(BURST_LEN - 1);
  assign tmo_hit     = stall && tmo == TW'(EMPTY_TMO - 1);
  assign o_busy      = state == BURST;
  // Arbitration/burst FSM plus the return path; the reader index is registered with each read so a word routes correctly after the grant drops
  always_ff @(posedge i_rclk or negedge i_rrst) begin
    if (!i_rrst) begin
      state   <= IDLE;
      ptr     <= PW'(NUM_REQ - 1);
      o_gnt   <= '0;
      beat    <= '0;
      tmo     <= '0;
      rd_q    <= 1'b0;
      rd_idx  <= '0;
      o_valid <= '0;
      o_data  <= '0;
    end else begin
      rd_q    <= o_fifo_rden;
      rd_idx  <= ptr;
      o_valid <= rd_q ? onehot(rd_idx) : '0;
      if (rd_q) o_data <= i_fifo_data;
      if (state == IDLE) begin
        if (|i_req) begin
          state <= BURST;
          ptr   <= win;
          o_gnt <= onehot(win);
          beat  <= '0;
          tmo   <= '0;
        end
      end else begin
        if (o_fifo_rden) begin
          beat <= beat == BW'(BURST_LEN) ? beat : beat + 1'b1;
          tmo  <= '0;
        end else if (stall && tmo != TW'(EMPTY_TMO)) begin
          tmo <= tmo + 1'b1;
        end
        if (last_beat || !i_req[ptr] || tmo_hit) begin
          state <= IDLE;
          o_gnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb_fifo_rd_sched: directed vector table plus hand sequences for fifo_rd_sched
module tb_fifo_rd_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'h0;
  logic       fe_force = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] rp = 8'd0, wp = 8'd0, fdata = 8'd0;
  logic       empty, rden, busy;
  logic [3:0] gnt, valid;
  logic [7:0] data;
  int cmp = 0, bad = 0;
  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       rden;
    logic [3:0] valid;
    logic [7:0] data;
    logic       busy;
  } vec_t;
  vec_t vec [24];
  assign empty = fe_force || rp == wp;
  fifo_rd_sched #(.NUM_REQ(4), .BURST_LEN(4), .EMPTY_TMO(8), .DATASIZE(8)) dut (
    .i_rclk(clk), .i_rrst(rst_n), .i_req(req), .o_gnt(gnt), .i_fifo_empty(empty),
    .o_fifo_rden(rden), .i_fifo_data(fdata), .o_data(data), .o_valid(valid), .o_busy(busy)
  );
  always #5 clk = ~clk;
  // Registered-output FIFO model: word appears the cycle after an accepted read
  always @(posedge clk) begin
    if (rden) begin
      fdata <= mem[rp];
      rp <= rp + 8'd1;
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic push(input logic [7:0] v);
    mem[wp] = v;
    wp = wp + 8'd1;
  endtask
  task automatic cyc(input logic [3:0] r, input logic f);
    @(negedge clk);
    req = r;
    fe_force = f;
    #1;
  endtask
  initial begin
    vec[0]  = '{4'hF, 4'h0, 1'b0, 4'h0, 8'd0,  1'b0};
    vec[1]  = '{4'hF, 4'h1, 1'b1, 4'h0, 8'd0,  1'b1};
    vec[2]  = '{4'hF, 4'h1, 1'b1, 4'h0, 8'd0,  1'b1};
    vec[3]  = '{4'hF, 4'h1, 1'b1, 4'h1, 8'd0,  1'b1};
    vec[4]  = '{4'hF, 4'h1, 1'b1, 4'h1, 8'd1,  1'b1};
    vec[5]  = '{4'hF, 4'h0, 1'b0, 4'h1, 8'd2,  1'b0};
    vec[6]  = '{4'hF, 4'h2, 1'b1, 4'h1, 8'd3,  1'b1};
    vec[7]  = '{4'hF, 4'h2, 1'b1, 4'h0, 8'd3,  1'b1};
    vec[8]  = '{4'hF, 4'h2, 1'b1, 4'h2, 8'd4,  1'b1};
    vec[9]  = '{4'hF, 4'h2, 1'b1, 4'h2, 8'd5,  1'b1};
    vec[10] = '{4'hF, 4'h0, 1'b0, 4'h2, 8'd6,  1'b0};
    vec[11] = '{4'hF, 4'h4, 1'b1, 4'h2, 8'd7,  1'b1};
    vec[12] = '{4'hF, 4'h4, 1'b1, 4'h0, 8'd7,  1'b1};
    vec[13] = '{4'hF, 4'h4, 1'b1, 4'h4, 8'd8,  1'b1};
    vec[14] = '{4'hF, 4'h4, 1'b1, 4'h4, 8'd9,  1'b1};
    vec[15] = '{4'hF, 4'h0, 1'b0, 4'h4, 8'd10, 1'b0};
    vec[16] = '{4'hF, 4'h8, 1'b1, 4'h4, 8'd11, 1'b1};
    vec[17] = '{4'hF, 4'h8, 1'b1, 4'h0, 8'd11, 1'b1};
    vec[18] = '{4'hF, 4'h8, 1'b1, 4'h8, 8'd12, 1'b1};
    vec[19] = '{4'hF, 4'h8, 1'b1, 4'h8, 8'd13, 1'b1};
    vec[20] = '{4'hF, 4'h0, 1'b0, 4'h8, 8'd14, 1'b0};
    vec[21] = '{4'hF, 4'h1, 1'b0, 4'h8, 8'd15, 1'b1};
    vec[22] = '{4'h0, 4'h1, 1'b0, 4'h0, 8'd15, 1'b1};
    vec[23] = '{4'h0, 4'h0, 1'b0, 4'h0, 8'd15, 1'b0};
    for (int i = 0; i < 16; i++) push(8'(i));
    // T1: reset held with all requests and a non-empty FIFO
    req = 4'hF;
    @(negedge clk);
    #1;
    chk("t1_gnt", gnt, 4'h0);
    chk("t1_rden", rden, 1'b0);
    chk("t1_valid", valid, 4'h0);
    chk("t1_data", data, 8'h00);
    chk("t1_busy", busy, 1'b0);
    @(negedge clk);
    req = 4'h0;
    rst_n = 1'b1;
    // T2: round robin over the vector table
    for (int i = 0; i < 24; i++) begin
      cyc(vec[i].req, 1'b0);
      chk($sformatf("t2_gnt[%0d]", i), gnt, vec[i].gnt);
      chk($sformatf("t2_rden[%0d]", i), rden, vec[i].rden);
      chk($sformatf("t2_valid[%0d]", i), valid, vec[i].valid);
      chk($sformatf("t2_data[%0d]", i), data, vec[i].data);
      chk($sformatf("t2_busy[%0d]", i), busy, vec[i].busy);
    end
    // T3: consumer1 requests for two reads then drops
    push(8'hA0);
    push(8'hA1);
    cyc(4'h2, 1'b0); chk("t3_arb_gnt", gnt, 4'h0);
    cyc(4'h2, 1'b0); chk("t3_gnt", gnt, 4'h2); chk("t3_rden0", rden, 1'b1);
    cyc(4'h2, 1'b0); chk("t3_rden1", rden, 1'b1);
    cyc(4'h0, 1'b0); chk("t3_drop_rden", rden, 1'b0); chk("t3_v0", valid, 4'h2); chk("t3_d0", data, 8'hA0);
    cyc(4'h0, 1'b0); chk("t3_gnt_off", gnt, 4'h0); chk("t3_v1", valid, 4'h2); chk("t3_d1", data, 8'hA1);
    cyc(4'h0, 1'b0); chk("t3_v_end", valid, 4'h0);
    // T4: consumer2 granted on an empty FIFO, times out, consumer3 follows
    cyc(4'hC, 1'b1); chk("t4_arb_gnt", gnt, 4'h0);
    for (int k = 0; k < 8; k++) begin
      cyc(4'hC, 1'b1);
      chk($sformatf("t4_gnt[%0d]", k), gnt, 4'h4);
      chk($sformatf("t4_rden[%0d]", k), rden, 1'b0);
    end
    cyc(4'hC, 1'b1); chk("t4_release_gnt", gnt, 4'h0); chk("t4_release_busy", busy, 1'b0);
    cyc(4'hC, 1'b1); chk("t4_next_gnt", gnt, 4'h8);
    cyc(4'h0, 1'b0); chk("t4_drop_gnt", gnt, 4'h8);
    cyc(4'h0, 1'b0); chk("t4_idle_gnt", gnt, 4'h0);
    // T5: FIFO goes empty for three cycles mid-burst
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
    cyc(4'h1, 1'b0); chk("t5_arb_gnt", gnt, 4'h0);
    cyc(4'h1, 1'b0); chk("t5_gnt", gnt, 4'h1); chk("t5_rd0", rden, 1'b1);
    cyc(4'h1, 1'b0); chk("t5_rd1", rden, 1'b1);
    cyc(4'h1, 1'b1); chk("t5_stall0", rden, 1'b0); chk("t5_v0", valid, 4'h1); chk("t5_d0", data, 8'hB0);
    cyc(4'h1, 1'b1); chk("t5_stall1", rden, 1'b0); chk("t5_v1", valid, 4'h1); chk("t5_d1", data, 8'hB1);
    cyc(4'h1, 1'b1); chk("t5_stall2", rden, 1'b0); chk("t5_gap_v", valid, 4'h0); chk("t5_hold_gnt", gnt, 4'h1);
    cyc(4'h1, 1'b0); chk("t5_rd2", rden, 1'b1);
    cyc(4'h1, 1'b0); chk("t5_rd3", rden, 1'b1); chk("t5_gnt_last", gnt, 4'h1);
    cyc(4'h1, 1'b0); chk("t5_idle_gnt", gnt, 4'h0); chk("t5_v2", valid, 4'h1); chk("t5_d2", data, 8'hB2);
    cyc(4'h1, 1'b0); chk("t5_regnt", gnt, 4'h1); chk("t5_rden_empty", rden, 1'b0); chk("t5_v3", valid, 4'h1); chk("t5_d3", data, 8'hB3);
    cyc(4'h0, 1'b0); chk("t5_v_end", valid, 4'h0);
    cyc(4'h0, 1'b0); chk("t5_end_gnt", gnt, 4'h0);
    // T6: reset asserted the cycle after a read drops the in-flight word
    push(8'hC0); push(8'hC1);
    cyc(4'hF, 1'b0); chk("t6_arb_gnt", gnt, 4'h0);
    cyc(4'hF, 1'b0); chk("t6_gnt", gnt, 4'h2); chk("t6_rden", rden, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", gnt, 4'h0); chk("t6_rst_rden", rden, 1'b0);
    chk("t6_rst_valid", valid, 4'h0); chk("t6_rst_busy", busy, 1'b0); chk("t6_rst_data", data, 8'h00);
    @(negedge clk);
    #1;
    chk("t6_rst_valid2", valid, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_rel_valid", valid, 4'h0);
    cyc(4'hF, 1'b0); chk("t6_regnt0", gnt, 4'h1); chk("t6_post_valid", valid, 4'h0); chk("t6_post_rden", rden, 1'b1);
    cyc(4'h0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
